// File: rtl/dvi_video_timing_tx.sv
// CH7301C DVI transmit timing: H/V/DE generation with 555 pixels packed into two registered
// 12-bit halves (IDF=3) for a board-level ODDR wrapper. i_clk is the pixel clock.
module dvi_video_timing_tx #(
  parameter int unsigned H_VISIBLE     = 1024,
  parameter int unsigned H_FRONT       = 24,
  parameter int unsigned H_SYNC        = 136,
  parameter int unsigned H_BACK        = 160,
  parameter int unsigned V_VISIBLE     = 768,
  parameter int unsigned V_FRONT       = 3,
  parameter int unsigned V_SYNC        = 6,
  parameter int unsigned V_BACK        = 29,
  parameter bit          SYNC_POLARITY = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [14:0] i_pixel_data,
  input  logic        i_pixel_valid,
  output logic        o_pixel_ready,
  input  logic        i_underflow_clear,
  output logic        o_underflow,
  output logic        o_frame_start,
  output logic [11:0] o_dvi_data_rise,
  output logic [11:0] o_dvi_data_fall,
  output logic        o_dvi_de,
  output logic        o_dvi_h,
  output logic        o_dvi_v
);

  localparam int unsigned HT = H_SYNC + H_BACK + H_VISIBLE + H_FRONT;
  localparam int unsigned VT = V_SYNC + V_BACK + V_VISIBLE + V_FRONT;
  localparam int unsigned HW = $clog2(HT);
  localparam int unsigned VW = $clog2(VT);

  // Window bounds held as inclusive last indices so they always fit the counter width.
  localparam logic [HW-1:0] H_LAST      = HW'(HT - 1);
  localparam logic [HW-1:0] H_SYNC_LAST = HW'(H_SYNC - 1);
  localparam logic [HW-1:0] H_VIS_FIRST = HW'(H_SYNC + H_BACK);
  localparam logic [HW-1:0] H_VIS_LAST  = HW'(H_SYNC + H_BACK + H_VISIBLE - 1);
  localparam logic [VW-1:0] V_LAST      = VW'(VT - 1);
  localparam logic [VW-1:0] V_SYNC_LAST = VW'(V_SYNC - 1);
  localparam logic [VW-1:0] V_VIS_FIRST = VW'(V_SYNC + V_BACK);
  localparam logic [VW-1:0] V_VIS_LAST  = VW'(V_SYNC + V_BACK + V_VISIBLE - 1);

  logic [HW-1:0] r_hcnt;
  logic [VW-1:0] r_vcnt;

  logic w_v_sync_row;
  logic w_v_vis_row;
  logic w_h_sync;
  logic w_h_vis;
  logic w_de;
  logic w_hs;
  logic w_fs;

  logic        r_de;
  logic        r_h;
  logic        r_v;
  logic        r_fs;
  logic        r_underflow;
  logic [11:0] r_rise;
  logic [11:0] r_fall;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
    end else if (r_hcnt == H_LAST) begin
      r_hcnt <= '0;
      r_vcnt <= (r_vcnt == V_LAST) ? '0 : r_vcnt + VW'(1);
    end else begin
      r_hcnt <= r_hcnt + HW'(1);
    end
  end

  // Hsync only in visible rows keeps H, V and DE mutually exclusive.
  always_comb begin
    w_v_sync_row = (r_vcnt <= V_SYNC_LAST);
    w_v_vis_row  = (r_vcnt >= V_VIS_FIRST) && (r_vcnt <= V_VIS_LAST);
    w_h_sync     = (r_hcnt <= H_SYNC_LAST);
    w_h_vis      = (r_hcnt >= H_VIS_FIRST) && (r_hcnt <= H_VIS_LAST);
    w_de         = w_v_vis_row && w_h_vis;
    w_hs         = w_v_vis_row && w_h_sync;
    w_fs         = (r_hcnt == '0) && (r_vcnt == '0);
  end

  assign o_pixel_ready = w_de;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_de        <= 1'b0;
      r_h         <= !SYNC_POLARITY;
      r_v         <= !SYNC_POLARITY;
      r_fs        <= 1'b0;
      r_underflow <= 1'b0;
      r_rise      <= '0;
      r_fall      <= '0;
    end else begin
      r_de <= w_de;
      r_h  <= w_hs ? SYNC_POLARITY : !SYNC_POLARITY;
      r_v  <= w_v_sync_row ? SYNC_POLARITY : !SYNC_POLARITY;
      r_fs <= w_fs;
      // A missing pixel in the visible window goes out as black; timing never stalls.
      if (w_de && i_pixel_valid) begin
        r_rise <= {1'b0, i_pixel_data[14:10], i_pixel_data[9:8], 4'b0000};
        r_fall <= {i_pixel_data[7:5], i_pixel_data[4:0], 4'b0000};
      end else begin
        r_rise <= '0;
        r_fall <= '0;
      end
      if (i_underflow_clear) begin
        r_underflow <= 1'b0;
      end else if (w_de && !i_pixel_valid) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign o_dvi_de        = r_de;
  assign o_dvi_h         = r_h;
  assign o_dvi_v         = r_v;
  assign o_frame_start   = r_fs;
  assign o_underflow     = r_underflow;
  assign o_dvi_data_rise = r_rise;
  assign o_dvi_data_fall = r_fall;

endmodule
